pe_psum_drain: RTL and testbench
================================

// Module: pe_psum_drain
// PURPOSE
//  Read side of the per-PE psum FIFO.
//  - Pops one packed entry when the FIFO is non-empty: ROWS x COLS signed psums, one finished output-row group.
//  - Requantizes each psum: optional ReLU, rounding right shift, saturation to int8.
//  - Streams the result out one row (COLS bytes) per beat on a valid/ready interface.
//  - Sits between a PE's psum FIFO and the column/output-buffer collector.
// PARAMETERS
//  PSUM_WIDTH  16  bit width of one signed psum (matches diff_demo_pkg)
//  ROWS        3   psum rows per FIFO entry
//  COLS        6   psum columns per FIFO entry (= bytes per output beat)
//  RD_LAT      1   cycles from fifo_rd_en_o to valid fifo_dout_i (>=1)
// PORTS
//  clk           input   1                     clock, rising edge
//  rst           input   1                     async reset, active-high
//  drain_en      input   1                     allow new FIFO pops
//  relu_en       input   1                     clamp negative psums to 0 before the shift
//  shift_i       input   4                     right-shift amount, sampled at entry capture
//  fifo_rd_en_o  output  1                     FIFO pop strobe
//  fifo_dout_i   input   ROWS*COLS*PSUM_WIDTH  packed entry
//  fifo_empty_i  input   1                     FIFO empty flag
//  out_data_o    output  COLS*8                one requantized row; col c at [c*8+:8]
//  out_valid_o   output  1                     out_data_o valid
//  out_ready_i   input   1                     consumer accepts the beat
//  out_last_o    output  1                     beat carries row ROWS-1 of the entry
//  busy_o        output  1                     state != IDLE
// BEHAVIOUR
//  Reset (rst=1, asynchronous): state=IDLE, row=0, hold reg=0.
//   All outputs read 0 while rst=1; fifo_rd_en_o is gated with !rst.
//   Reset mid-operation discards the held entry; a pending FIFO read is lost (no replay).
//  Packing: psum(row r, col c) = fifo_dout_i[(r*COLS+c)*PSUM_WIDTH +: PSUM_WIDTH].
//   Row 0 is sent first.
//  FSM states: IDLE, WAIT, SEND.
//   IDLE: fifo_rd_en_o = drain_en & !fifo_empty_i (combinational).
//    If it is 1 -> WAIT; wait counter loads RD_LAT-1.
//   WAIT: counts down. When the count is 0, at the clock edge:
//    capture fifo_dout_i and shift_i into the hold reg -> SEND, row=0.
//   SEND: out_valid_o=1; out_data_o = requant(hold row `row`); out_last_o = (row==ROWS-1).
//    ready=0: hold. Data, row and last stay stable; no FIFO pop.
//    ready=1 and row<ROWS-1: row++.
//    ready=1 and row==ROWS-1: row=0.
//     If drain_en & !fifo_empty_i: fifo_rd_en_o=1 this same cycle -> WAIT.
//     Otherwise -> IDLE.
//  Strobe and flag rules:
//   fifo_rd_en_o is never asserted when fifo_empty_i=1, nor outside IDLE / last-row handshake.
//   Exactly one pop per entry.
//   drain_en=0 only blocks new pops; the entry in flight completes.
//  Latency, empty FIFO to first beat: entry written -> fifo_empty_i low (FIFO's own latency)
//   -> pop cycle -> RD_LAT cycles -> out_valid_o.
//  Throughput: ROWS+RD_LAT cycles per entry under continuous ready.
//  Requant, per psum p (signed PSUM_WIDTH, computed in PSUM_WIDTH+1 bits):
//   q = (relu_en && p<0) ? 0 : p;
//   if s=shift>0: q = (q + (1<<(s-1))) >>> s   (round half up)
//   out = sat(q, -128, 127).
//   shift_i changes take effect only at the next capture.
// TESTING
//  1. 1 entry, all psums=100, shift=0, relu=0, ready=1
//     -> 3 beats, every byte 0x64; last on beat 3 only; exactly 1 rd_en pulse.
//  2. Saturation and rounding, entry {300,-300,302,7,-7,0}:
//     shift=0 -> 0x7F,0x80; shift=2 -> 300->75, 302->76, 7->2, -7->0xFE.
//  3. relu_en=1, psum=-5 -> 0x00. relu_en=0, psum=-5 -> 0xFB.
//  4. ready=0 for 5 cycles while row=1 is presented
//     -> out_data_o/out_last_o stable, no rd_en; row 2 follows ready=1.
//  5. 2 entries queued, ready=1 -> 6 beats.
//     2nd rd_en is in the same cycle as the beat-3 handshake.
//     FIFO empty afterwards -> no further rd_en; busy_o drops.
//  6. rst pulse during SEND row 1 -> outputs 0 immediately, state IDLE.
//     With drain_en=0, a non-empty FIFO is not popped.

Source files
------------

// File: rtl/pe_psum_drain.sv
// rtl/pe_psum_drain.sv - psum FIFO read side: pop, requantize to int8, stream one row per beat

module pe_psum_drain #(
    parameter int PSUM_WIDTH = 16,
    parameter int ROWS       = 3,
    parameter int COLS       = 6,
    parameter int RD_LAT     = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            drain_en,
    input  logic                            relu_en,
    input  logic [3:0]                      shift_i,
    output logic                            fifo_rd_en_o,
    input  logic [ROWS*COLS*PSUM_WIDTH-1:0] fifo_dout_i,
    input  logic                            fifo_empty_i,
    output logic [COLS*8-1:0]               out_data_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic                            out_last_o,
    output logic                            busy_o
);

    localparam int EW = ROWS * COLS * PSUM_WIDTH;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(RD_LAT - 1);
    localparam logic signed [PSUM_WIDTH:0] QMAX = 127;
    localparam logic signed [PSUM_WIDTH:0] QMIN = -128;

    typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

    state_t          state, state_nxt;
    logic [RW-1:0]   row;
    logic [CW-1:0]   wait_cnt;
    logic [EW-1:0]   hold;
    logic [3:0]      hold_shift;
    logic            pop;
    logic [COLS*8-1:0] row_bytes;

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic logic [7:0] requant(input logic signed [PSUM_WIDTH-1:0] p,
                                           input logic relu, input logic [3:0] s);
        logic signed [PSUM_WIDTH:0] q;
        logic signed [PSUM_WIDTH:0] rnd;
        q = {p[PSUM_WIDTH-1], p};
        if (relu && p[PSUM_WIDTH-1])
            q = '0;
        if (s != 4'd0) begin
            rnd = (PSUM_WIDTH+1)'(1) << (s - 4'd1);
            q   = (q + rnd) >>> s;
        end
        if (q > QMAX)
            return 8'h7F;
        else if (q < QMIN)
            return 8'h80;
        else
            return q[7:0];
    endfunction

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (drain_en && !fifo_empty_i) begin
                    pop       = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == '0)
                    state_nxt = SEND;
            end
            SEND: begin
                if (out_ready_i && row == LAST_ROW) begin
                    if (drain_en && !fifo_empty_i) begin
                        pop       = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            wait_cnt   <= '0;
            hold       <= '0;
            hold_shift <= '0;
        end else begin
            state <= state_nxt;
            if (pop)
                wait_cnt <= WAIT_LOAD;
            else if (state == WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;

            if (state == WAIT && wait_cnt == '0) begin
                hold       <= fifo_dout_i;
                hold_shift <= shift_i;
                row        <= '0;
            end else if (state == SEND && out_ready_i) begin
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end
        end
    end

    always_comb begin
        row_bytes = '0;
        for (int c = 0; c < COLS; c++)
            row_bytes[c*8 +: 8] = requant(hold[(int'(row)*COLS + c)*PSUM_WIDTH +: PSUM_WIDTH],
                                          relu_en, hold_shift);
    end

    assign fifo_rd_en_o = pop & ~rst;
    assign out_valid_o  = (state == SEND);
    assign out_last_o   = (state == SEND) && (row == LAST_ROW);
    assign out_data_o   = (state == SEND) ? row_bytes : '0;
    assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_pe_psum_drain.sv
// tb/tb_pe_psum_drain.sv - self-checking bench for pe_psum_drain with FIFO and requant reference model

module tb_pe_psum_drain;

    localparam int PW   = 16;
    localparam int ROWS = 3;
    localparam int COLS = 6;
    localparam int EW   = ROWS * COLS * PW;

    logic          clk;
    logic          rst;
    logic          drain_en;
    logic          relu_en;
    logic [3:0]    shift;
    logic          fifo_rd_en_o;
    logic [EW-1:0] fifo_dout;
    logic          fifo_empty;
    logic [COLS*8-1:0] out_data_o;
    logic          out_valid_o;
    logic          out_ready;
    logic          out_last_o;
    logic          busy_o;

    pe_psum_drain #(.PSUM_WIDTH(PW), .ROWS(ROWS), .COLS(COLS), .RD_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .drain_en     (drain_en),
        .relu_en      (relu_en),
        .shift_i      (shift),
        .fifo_rd_en_o (fifo_rd_en_o),
        .fifo_dout_i  (fifo_dout),
        .fifo_empty_i (fifo_empty),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready),
        .out_last_o   (out_last_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int n_rd = 0, n_beats = 0, rd_on_last = 0;
    logic idle_s;
    logic [COLS*8-1:0] last_beat;
    logic [EW-1:0]     fq[$];
    logic [COLS*8-1:0] exp_data[$];
    logic              exp_last[$];
    int                ent[ROWS][COLS];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    function automatic int ref_q(input int p, input bit relu, input int s);
        int q;
        q = (relu && p < 0) ? 0 : p;
        if (s > 0)
            q = (q + (1 << (s - 1))) >>> s;
        if (q > 127) return 127;
        if (q < -128) return -128;
        return q;
    endfunction

    task automatic push_entry();
        logic [EW-1:0]     w;
        logic [COLS*8-1:0] b;
        w = '0;
        for (int r = 0; r < ROWS; r++) begin
            b = '0;
            for (int c = 0; c < COLS; c++) begin
                w[(r*COLS + c)*PW +: PW] = PW'(ent[r][c]);
                b[c*8 +: 8] = 8'(ref_q(ent[r][c], relu_en, int'(shift)));
            end
            exp_data.push_back(b);
            exp_last.push_back(r == ROWS - 1);
        end
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic fill_all(input int v);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                ent[r][c] = v;
    endtask

    task automatic fill_random();
        bit wide;
        wide = 1'($urandom_range(0, 1));
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                ent[r][c] = wide ? int'($urandom_range(0, 65535)) - 32768
                                 : int'($urandom_range(0, 1023)) - 512;
    endtask

    // One clock: check outputs at the falling edge, then update the FIFO model after the rising edge.
    task automatic tick();
        logic rd, hs;
        @(negedge clk);
        rd = fifo_rd_en_o;
        hs = out_valid_o && out_ready;
        if (rd) begin
            n_rd++;
            check("rd_en_nonempty", 64'(fifo_empty), 64'd0);
            check("rd_en_timing", 64'((!busy_o) || (hs && out_last_o)), 64'd1);
            if (hs && out_last_o) rd_on_last++;
        end
        if (out_valid_o) begin
            check("beat_expected", 64'(exp_data.size() != 0), 64'd1);
            if (exp_data.size() != 0) begin
                check("beat_data", 64'(out_data_o), 64'(exp_data[0]));
                check("beat_last", 64'(out_last_o), 64'(exp_last[0]));
                if (hs) begin
                    last_beat = out_data_o;
                    void'(exp_data.pop_front());
                    void'(exp_last.pop_front());
                    n_beats++;
                end
            end
        end
        idle_s = !busy_o && !rd && exp_data.size() == 0 && fifo_empty;
        @(posedge clk);
        #1;
        if (rd) begin
            if (fq.size() != 0) fifo_dout = fq.pop_front();
            fifo_empty = (fq.size() == 0);
        end
    endtask

    task automatic run_until_idle(input int budget, output int n);
        n = 0;
        idle_s = 1'b0;
        while (!idle_s && n < budget) begin
            tick();
            n++;
        end
        check("drain_complete", 64'(idle_s), 64'd1);
    endtask

    initial begin
        int n, rd0, b0;
        rst = 1'b1; drain_en = 1'b0; relu_en = 1'b0; shift = 4'd0;
        out_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = '0; last_beat = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_last", 64'(out_last_o), 64'd0);
        check("rst_data", 64'(out_data_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: single entry of 100s
        drain_en = 1'b1; out_ready = 1'b1;
        fill_all(100); rd0 = n_rd; b0 = n_beats;
        push_entry();
        run_until_idle(50, n);
        check("t1_rd_pulses", 64'(n_rd - rd0), 64'd1);
        check("t1_beats", 64'(n_beats - b0), 64'd3);
        check("t1_cycles", 64'(n), 64'd6);
        check("t1_bytes", 64'(last_beat), 64'h6464_6464_6464);

        // 2: saturation and rounding
        for (int r = 0; r < ROWS; r++) begin
            ent[r][0] = 300; ent[r][1] = -300; ent[r][2] = 302;
            ent[r][3] = 7;   ent[r][4] = -7;   ent[r][5] = 0;
        end
        shift = 4'd0; push_entry();
        run_until_idle(50, n);
        check("t2_shift0", 64'(last_beat), 64'h00F9_077F_807F);
        shift = 4'd2; push_entry();
        run_until_idle(50, n);
        check("t2_shift2", 64'(last_beat), 64'h00FE_024C_B54B);

        // 3: relu
        shift = 4'd0; fill_all(-5);
        relu_en = 1'b1; push_entry();
        run_until_idle(50, n);
        check("t3_relu_on", 64'(last_beat), 64'h0);
        relu_en = 1'b0; push_entry();
        run_until_idle(50, n);
        check("t3_relu_off", 64'(last_beat), 64'hFBFB_FBFB_FBFB);

        // 4: backpressure on row 1 with a second entry waiting
        shift = 4'($urandom_range(0, 6));
        fill_random(); push_entry();
        fill_random(); push_entry();
        rd0 = n_rd; b0 = n_beats; n = 0;
        while (n_beats == b0 && n < 20) begin tick(); n++; end
        check("t4_row0_accepted", 64'(n_beats - b0), 64'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_stall_rd", 64'(fifo_rd_en_o), 64'd0);
            check("t4_stall_last", 64'(out_last_o), 64'd0);
            check("t4_stall_valid", 64'(out_valid_o), 64'd1);
        end
        out_ready = 1'b1;
        run_until_idle(50, n);
        check("t4_rd_pulses", 64'(n_rd - rd0), 64'd2);
        check("t4_beats", 64'(n_beats - b0), 64'd6);

        // 5: two queued entries back to back
        shift = 4'($urandom_range(0, 8)); relu_en = 1'($urandom_range(0, 1));
        fill_random(); push_entry();
        fill_random(); push_entry();
        rd0 = n_rd; b0 = n_beats; rd_on_last = 0;
        run_until_idle(50, n);
        check("t5_rd_pulses", 64'(n_rd - rd0), 64'd2);
        check("t5_rd_on_last", 64'(rd_on_last), 64'd1);
        check("t5_beats", 64'(n_beats - b0), 64'd6);
        check("t5_cycles", 64'(n), 64'd10);
        check("t5_busy_end", 64'(busy_o), 64'd0);

        // Random soak: random ready and drain_en
        shift = 4'($urandom_range(0, 9)); relu_en = 1'($urandom_range(0, 1));
        rd0 = n_rd;
        for (int e = 0; e < 12; e++) begin fill_random(); push_entry(); end
        for (int i = 0; i < 150; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            drain_en  = ($urandom_range(0, 9) < 8);
            tick();
        end
        out_ready = 1'b1; drain_en = 1'b1;
        run_until_idle(200, n);
        check("soak_rd_pulses", 64'(n_rd - rd0), 64'd12);

        // 6: reset during SEND row 1, then no pop while drain_en=0
        relu_en = 1'b0; shift = 4'd1;
        fill_random(); push_entry();
        b0 = n_beats; n = 0;
        while (n_beats == b0 && n < 20) begin tick(); n++; end
        drain_en = 1'b0; out_ready = 1'b0;
        fill_random(); push_entry();
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid_o), 64'd0);
        check("t6_rst_busy", 64'(busy_o), 64'd0);
        check("t6_rst_data", 64'(out_data_o), 64'd0);
        check("t6_rst_last", 64'(out_last_o), 64'd0);
        check("t6_rst_rd", 64'(fifo_rd_en_o), 64'd0);
        for (int i = 0; i < ROWS - 1; i++) begin
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
        end
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_no_pop", 64'(fifo_rd_en_o), 64'd0);
            check("t6_idle", 64'(busy_o), 64'd0);
        end
        drain_en = 1'b1; out_ready = 1'b1; b0 = n_beats;
        run_until_idle(50, n);
        check("t6_resume_beats", 64'(n_beats - b0), 64'd3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
